// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: arbiter FSM states, port ids, default memory widths.
package sap1_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam int unsigned SAP1_ADDR_W = 8;
  localparam int unsigned SAP1_DATA_W = 8;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bus of the SRAM port arbiter: CPU read port and loader read/write port.
//   master : driven by the requesters (req/addr/we/wdata out, rdata/ack in)
//   slave  : the arbiter (req/addr/we/wdata in, rdata/ack out)
interface sram_port_arbiter_if
  import sap1_pkg::*;
#(
  parameter int unsigned ADDR_W = SAP1_ADDR_W,
  parameter int unsigned DATA_W = SAP1_DATA_W
);

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_ack;

  modport master (
    output cpu_req, cpu_addr,
    input  cpu_rdata, cpu_ack,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_rdata, ldr_ack
  );

  modport slave (
    input  cpu_req, cpu_addr,
    output cpu_rdata, cpu_ack,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_rdata, ldr_ack
  );

endinterface

// File: rtl/sram_strobe_timer.sv
// Strobe-length down-counter: load arms WAIT_CYC cycles, expire_c flags the last one.
//   clk, clr   : clock, async active-low reset
//   load       : load WAIT_CYC-1 (asserted in the cycle before the strobe window)
//   expire_c   : high when the counter has reached zero
module sram_strobe_timer #(
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  output logic expire_c
);

  localparam int unsigned CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire_c = (cnt == '0);

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter and strobe sequencer for the single external async SRAM,
// shared by the SAP-1 CPU (read-only) and the program loader (read/write).
//   clk, clr          : clock, async active-low reset
//   bus (slave)       : CPU and loader request/ack ports
//   A, DQ, CE, WE, OE : SRAM pins (strobes active-low, DQ tri-stated unless writing)
//   busy              : high whenever the access FSM is not IDLE
//   cpu_cnt, ldr_cnt  : saturating per-port ack counters, only with ARB_STATS_EN
module sram_port_arbiter
  import sap1_pkg::*;
#(
  parameter int unsigned ADDR_W   = SAP1_ADDR_W,
  parameter int unsigned DATA_W   = SAP1_DATA_W,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic                 clk,
  input  logic                 clr,
  sram_port_arbiter_if.slave   bus,
  output logic [ADDR_W-1:0]    A,
  inout  wire  [DATA_W-1:0]    DQ,
  output logic                 CE,
  output logic                 WE,
  output logic                 OE,
`ifdef ARB_STATS_EN
  output logic [15:0]          cpu_cnt,
  output logic [15:0]          ldr_cnt,
`endif
  output logic                 busy
);

  arb_state_t        state;
  logic              gnt;
  logic              we_q;
  logic              last_grant;
  logic              dq_en;
  logic [DATA_W-1:0] dq_out;
  logic              grant_c;
  logic              grant_we_c;
  logic              expire_c;

  // DQ driven only while a loader write owns the bus.
  assign DQ = dq_en ? dq_out : {DATA_W{1'bz}};

  // Round-robin pick; on a tie the port that did not win last time goes first.
  always_comb begin
    grant_c = PORT_CPU;
    if (bus.cpu_req && bus.ldr_req) begin
      grant_c = ~last_grant;
    end else if (bus.ldr_req) begin
      grant_c = PORT_LDR;
    end
    grant_we_c = (grant_c == PORT_LDR) && bus.ldr_we;
  end

  sram_strobe_timer #(
    .WAIT_CYC (WAIT_CYC)
  ) u_timer (
    .clk      (clk),
    .clr      (clr),
    .load     (state == SETUP),
    .expire_c (expire_c)
  );

  // Access FSM; every pin is a register so strobes never depend on req combinationally.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state         <= IDLE;
      gnt           <= PORT_CPU;
      we_q          <= 1'b0;
      last_grant    <= PORT_LDR;
      dq_en         <= 1'b0;
      dq_out        <= '0;
      A             <= '0;
      CE            <= 1'b1;
      WE            <= 1'b1;
      OE            <= 1'b1;
      busy          <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      bus.ldr_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.ldr_rdata <= '0;
    end else begin
      bus.cpu_ack <= 1'b0;
      bus.ldr_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req || bus.ldr_req) begin
            state  <= SETUP;
            busy   <= 1'b1;
            gnt    <= grant_c;
            we_q   <= grant_we_c;
            A      <= (grant_c == PORT_LDR) ? bus.ldr_addr : bus.cpu_addr;
            dq_out <= bus.ldr_wdata;
            dq_en  <= grant_we_c;
            CE     <= 1'b0;
            OE     <= grant_we_c;
            WE     <= 1'b1;
          end
        end
        SETUP: begin
          state <= STROBE;
          if (we_q) begin
            WE <= 1'b0;
          end
        end
        STROBE: begin
          if (expire_c) begin
            state      <= HOLD;
            WE         <= 1'b1;
            OE         <= 1'b1;
            last_grant <= gnt;
            if (gnt == PORT_CPU) begin
              bus.cpu_ack <= 1'b1;
            end else begin
              bus.ldr_ack <= 1'b1;
            end
            if (!we_q) begin
              if (gnt == PORT_CPU) begin
                bus.cpu_rdata <= DQ;
              end else begin
                bus.ldr_rdata <= DQ;
              end
            end
          end
        end
        HOLD: begin
          state <= IDLE;
          busy  <= 1'b0;
          CE    <= 1'b1;
          dq_en <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          CE    <= 1'b1;
          WE    <= 1'b1;
          OE    <= 1'b1;
          dq_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  // Saturating ack counters.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cpu_cnt <= '0;
      ldr_cnt <= '0;
    end else begin
      if (bus.cpu_ack && (cpu_cnt != 16'hFFFF)) begin
        cpu_cnt <= cpu_cnt + 16'd1;
      end
      if (bus.ldr_ack && (ldr_cnt != 16'hFFFF)) begin
        ldr_cnt <= ldr_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural async SRAM model.
module tb_sram_port_arbiter;
  import sap1_pkg::*;

  localparam int unsigned WAIT_CYC = 2;
  localparam int LAT = WAIT_CYC + 2;

  logic clk = 1'b0;
  logic clr = 1'b0;
  wire  [7:0] dq;
  logic [7:0] a;
  logic ce, we_n, oe_n, busy;
`ifdef ARB_STATS_EN
  logic [15:0] cpu_cnt, ldr_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_cpu_rd = 8'h00;
  logic [7:0] exp_ldr_rd = 8'h00;

  sram_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  sram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYC(WAIT_CYC)) dut (
    .clk  (clk),
    .clr  (clr),
    .bus  (bus),
    .A    (a),
    .DQ   (dq),
    .CE   (ce),
    .WE   (we_n),
    .OE   (oe_n),
`ifdef ARB_STATS_EN
    .cpu_cnt (cpu_cnt),
    .ldr_cnt (ldr_cnt),
`endif
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Behavioural async SRAM: drives on read, latches on WE rising.
  logic [7:0] mem [256];
  assign dq = (!ce && !oe_n && we_n) ? mem[a] : 8'bz;
  always @(posedge we_n) if (!ce) mem[a] = dq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Strobe-legality monitor.
  always @(negedge clk) begin
    if (clr) begin
      checks++;
      if (!we_n && !oe_n) begin
        failures++;
        $display("FAIL we_oe_overlap actual=both_low required=not_both_low");
      end
      if (dut.dq_en && !oe_n) begin
        failures++;
        $display("FAIL dq_drive_while_oe actual=driven required=released");
      end
      if (bus.cpu_ack && bus.ldr_ack) begin
        failures++;
        $display("FAIL ack_overlap actual=both required=one");
      end
    end
  end

  typedef struct {
    logic       port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic do_reset();
    clr = 1'b0;
    bus.cpu_req = 1'b0;
    bus.ldr_req = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    exp_cpu_rd = 8'h00;
    exp_ldr_rd = 8'h00;
    @(negedge clk);
  endtask

  // One access on an idle FSM: latency, strobe widths, DQ drive and read data.
  task automatic run_access(input logic port, input logic wr, input logic [7:0] addr,
                            input logic [7:0] wdata, input logic [7:0] exp_rd);
    int lat = 0;
    int we_low = 0;
    int oe_low = 0;
    bit dq_ok = 1'b1;
    if (port == PORT_CPU) begin
      bus.cpu_req = 1'b1; bus.cpu_addr = addr;
    end else begin
      bus.ldr_req = 1'b1; bus.ldr_we = wr; bus.ldr_addr = addr; bus.ldr_wdata = wdata;
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!we_n) we_low++;
      if (!oe_n) oe_low++;
      if (wr && !ce && !(dut.dq_en && dq == wdata)) dq_ok = 1'b0;
      if (!wr && dut.dq_en) dq_ok = 1'b0;
      if ((port == PORT_CPU) ? bus.cpu_ack : bus.ldr_ack) begin
        lat = i;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    bus.ldr_req = 1'b0;
    check("ack_latency", lat, LAT);
    check("we_low_cycles", we_low, wr ? WAIT_CYC : 0);
    check("oe_low_cycles", oe_low, wr ? 0 : WAIT_CYC + 1);
    check("dq_drive", dq_ok, 1);
    if (!wr) begin
      if (port == PORT_CPU) exp_cpu_rd = exp_rd; else exp_ldr_rd = exp_rd;
    end
    check("cpu_rdata", bus.cpu_rdata, exp_cpu_rd);
    check("ldr_rdata", bus.ldr_rdata, exp_ldr_rd);
    @(negedge clk);
    check("ack_one_cycle", {bus.cpu_ack, bus.ldr_ack}, 0);
    check("idle_after", {busy, ce}, 2'b01);
  endtask

  initial begin
    int prev;
    int t;
    int lat;
    logic [3:0] seen;
    bit got;

    foreach (mem[i]) mem[i] = 8'h00;
    mem[0] = 8'h1E;
    bus.cpu_req = 1'b0; bus.cpu_addr = 8'h00;
    bus.ldr_req = 1'b0; bus.ldr_we = 1'b0; bus.ldr_addr = 8'h00; bus.ldr_wdata = 8'h00;

    vecs[0] = '{PORT_LDR, 1'b1, 8'h0F, 8'h2A, 8'h00};
    vecs[1] = '{PORT_LDR, 1'b0, 8'h0F, 8'h00, 8'h2A};
    vecs[2] = '{PORT_CPU, 1'b0, 8'h00, 8'h00, 8'h1E};
    vecs[3] = '{PORT_CPU, 1'b0, 8'h0F, 8'h00, 8'h2A};
    vecs[4] = '{PORT_LDR, 1'b1, 8'hFF, 8'h55, 8'h00};
    vecs[5] = '{PORT_CPU, 1'b0, 8'hFF, 8'h00, 8'h55};
    vecs[6] = '{PORT_LDR, 1'b1, 8'h00, 8'hC3, 8'h00};
    vecs[7] = '{PORT_LDR, 1'b0, 8'h00, 8'h00, 8'hC3};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_strobes", {ce, we_n, oe_n}, 3'b111);
    check("rst_addr", a, 0);
    check("rst_dq_en", dut.dq_en, 0);
    check("rst_acks_busy", {bus.cpu_ack, bus.ldr_ack, busy}, 0);
    check("rst_rdata", {bus.cpu_rdata, bus.ldr_rdata}, 0);
    clr = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 8; k++)
      run_access(vecs[k].port, vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].rdata);

    // Both ports requesting continuously from reset: CPU, LDR, CPU, LDR
    do_reset();
    bus.cpu_addr = 8'h00;
    bus.ldr_we = 1'b0; bus.ldr_addr = 8'hFF;
    bus.cpu_req = 1'b1; bus.ldr_req = 1'b1;
    prev = 0;
    t = 0;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        t++;
        if (bus.cpu_ack || bus.ldr_ack) begin got = 1'b1; break; end
      end
      check("rr_ack_seen", got, 1);
      check("rr_order", {bus.cpu_ack, bus.ldr_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
      check("rr_spacing", t - prev, (k == 0) ? LAT : WAIT_CYC + 3);
      prev = t;
      if (k == 3) begin bus.cpu_req = 1'b0; bus.ldr_req = 1'b0; end
      @(negedge clk);
      t++;
      check("rr_ack_width", {bus.cpu_ack, bus.ldr_ack}, 0);
    end
    check("rr_cpu_rdata", bus.cpu_rdata, 8'hC3);
    check("rr_ldr_rdata", bus.ldr_rdata, 8'h55);

    // cpu_req dropped in SETUP; loader waiting gets the next grant
    bus.cpu_addr = 8'h0F; bus.cpu_req = 1'b1;
    bus.ldr_we = 1'b1; bus.ldr_addr = 8'h10; bus.ldr_wdata = 8'h77; bus.ldr_req = 1'b1;
    seen = '0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) bus.cpu_req = 1'b0;
      if (bus.cpu_ack) begin seen[0] = 1'b1; check("drop_cpu_lat", i, LAT); end
      if (bus.ldr_ack) begin seen[1] = 1'b1; lat = i; bus.ldr_req = 1'b0; break; end
    end
    check("drop_acks_seen", seen[1:0], 2'b11);
    check("drop_ldr_lat", lat, LAT + WAIT_CYC + 3);
    check("drop_cpu_rdata", bus.cpu_rdata, 8'h2A);
    exp_cpu_rd = 8'h2A;
    exp_ldr_rd = 8'h55;
    @(negedge clk);
    run_access(PORT_CPU, 1'b0, 8'h10, 8'h00, 8'h77);

    // Reset in the middle of a loader write strobe
    bus.ldr_we = 1'b1; bus.ldr_addr = 8'h20; bus.ldr_wdata = 8'h99; bus.ldr_req = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_rst_we_low", we_n, 0);
    #2 clr = 1'b0;
    #1;
    check("midrst_strobes", {ce, we_n, oe_n}, 3'b111);
    check("midrst_dq_en", dut.dq_en, 0);
    check("midrst_busy", busy, 0);
    bus.ldr_req = 1'b0;
    got = 1'b0;
    repeat (2) begin @(negedge clk); if (bus.ldr_ack) got = 1'b1; end
    clr = 1'b1;
    repeat (4) begin @(negedge clk); if (bus.ldr_ack) got = 1'b1; end
    check("midrst_no_ack", got, 0);
    check("midrst_idle", {busy, ce}, 2'b01);
    check("midrst_rdata", {bus.cpu_rdata, bus.ldr_rdata}, 0);

`ifdef ARB_STATS_EN
    do_reset();
    check("cnt_rst", {cpu_cnt, ldr_cnt}, 0);
    for (int k = 0; k < 3; k++) run_access(PORT_CPU, 1'b0, 8'h00, 8'h00, 8'hC3);
    for (int k = 0; k < 2; k++) run_access(PORT_LDR, 1'b0, 8'hFF, 8'h00, 8'h55);
    check("cpu_cnt", cpu_cnt, 3);
    check("ldr_cnt", ldr_cnt, 2);
    force dut.cpu_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.cpu_cnt;
    run_access(PORT_CPU, 1'b0, 8'h00, 8'h00, 8'hC3);
    check("cpu_cnt_sat", cpu_cnt, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
